// File: rtl/epcs_pkg.sv
// ---------------------------------------------------------------------------
// epcs_pkg
// Shared definitions for the EPCS serial flash reader:
//   - READ_OPCODE : serial flash READ command byte
//   - BIT_CNT_W   : width of the frame bit counter (up to 64 bits per frame)
//   - FRAME_FULL / FRAME_DATA : frame lengths (opcode+address+data / data only)
//   - epcs_state_t : reader FSM state encoding
//   - byte_reorder : maps the serial receive order onto the little-endian bus word
// ---------------------------------------------------------------------------
package epcs_pkg;

    localparam logic [7:0] READ_OPCODE = 8'h03;

    localparam int BIT_CNT_W = 7;
    localparam logic [BIT_CNT_W-1:0] FRAME_FULL = 7'd64;
    localparam logic [BIT_CNT_W-1:0] FRAME_DATA = 7'd32;

    // ST_HOLD is only reachable when burst continuation is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_DONE     = 3'd3,
        ST_CS_HIGH  = 3'd4,
        ST_HOLD     = 3'd5
    } epcs_state_t;

    // The first byte off the wire (lowest flash address) lands in rx[31:24];
    // the bus expects it in [7:0].
    function automatic logic [31:0] byte_reorder(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/epcs_flash_reader_if.sv
// ---------------------------------------------------------------------------
// epcs_flash_reader_if
// PicoRV32 native-bus slice seen by the flash reader.
//   sel        : mem_valid qualified by the flash window decode
//   mem_addr   : byte address within the flash (bits [1:0] ignored)
//   mem_wstrb  : nonzero marks a write
//   mem_ready  : one-cycle completion pulse
//   mem_rdata  : read data, valid while mem_ready is high
//
// Handshake: the initiator raises sel with a stable mem_addr/mem_wstrb and
// holds them until it sees mem_ready=1 on a clock edge; that edge completes
// the transfer. mem_ready is a single-cycle pulse and never repeats on the
// following cycle. The responder samples sel only while idle.
// ---------------------------------------------------------------------------
interface epcs_flash_reader_if;
    logic        sel;
    logic [23:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output sel, mem_addr, mem_wstrb, input mem_ready, mem_rdata);
    modport slave  (input sel, mem_addr, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/epcs_spi_shifter.sv
// ---------------------------------------------------------------------------
// epcs_spi_shifter
// SPI mode-0 frame engine. A go pulse starts a frame of frame_len dclk
// periods; each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
// tx_word is shifted out MSB first, followed by zeros; data0 is shifted into
// rx_word on the clk_sys edge where dclk rises, so rx_word holds the last 32
// bits received. done pulses on the edge that ends the final high phase.
// Ports:
//   clk_sys, reset_n : clock, async active-low reset
//   go               : start a frame (only while idle)
//   frame_len        : number of dclk periods in the frame
//   tx_word          : bits to send first, MSB first
//   data0            : serial data from the flash
//   dclk, asdo       : SPI clock (idle low) and serial data to the flash
//   done             : frame complete
//   rx_word          : last 32 received bits, first received in the MSB
// ---------------------------------------------------------------------------
module epcs_spi_shifter
    import epcs_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 go,
    input  logic [BIT_CNT_W-1:0] frame_len,
    input  logic [31:0]          tx_word,
    input  logic                 data0,
    output logic                 dclk,
    output logic                 asdo,
    output logic                 done,
    output logic [31:0]          rx_word
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic                 busy;
    logic                 dclk_q;
    logic                 asdo_q;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] last_bit;
    logic [31:0]          tx_sr;
    logic [31:0]          rx_sr;
    logic                 tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            dclk_q   <= 1'b0;
            asdo_q   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else if (go) begin
            // First bit goes out now so it is stable for the whole first low phase.
            busy     <= 1'b1;
            dclk_q   <= 1'b0;
            asdo_q   <= tx_word[31];
            div_cnt  <= '0;
            bit_cnt  <= '0;
            last_bit <= frame_len - 7'd1;
            tx_sr    <= {tx_word[30:0], 1'b0};
        end else if (busy) begin
            if (!tick) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                if (!dclk_q) begin
                    dclk_q <= 1'b1;
                    rx_sr  <= {rx_sr[30:0], data0};
                end else begin
                    dclk_q  <= 1'b0;
                    bit_cnt <= bit_cnt + 7'd1;
                    if (bit_cnt == last_bit) begin
                        busy   <= 1'b0;
                        asdo_q <= 1'b0;
                    end else begin
                        asdo_q <= tx_sr[31];
                        tx_sr  <= {tx_sr[30:0], 1'b0};
                    end
                end
            end
        end
    end

    assign done    = busy && tick && dclk_q && (bit_cnt == last_bit);
    assign dclk    = dclk_q;
    assign asdo    = asdo_q;
    assign rx_word = rx_sr;

endmodule

// File: rtl/epcs_flash_reader.sv
// ---------------------------------------------------------------------------
// epcs_flash_reader
// Read-only PicoRV32 bus responder returning 32-bit words from the EPCS
// configuration flash using the READ (0x03) command in SPI mode 0.
// Writes are acknowledged one cycle after acceptance and discarded.
// Ports:
//   clk_sys, reset_n : clock, async active-low reset
//   bus              : native-bus slice (sel/mem_addr/mem_wstrb in,
//                      mem_ready/mem_rdata out)
//   dclk, ncs, asdo  : flash clock, chip select (active low), serial out
//   data0            : serial data from the flash
//   state_dbg        : current FSM state
// Parameters:
//   CLK_DIV        : clk_sys cycles per dclk half-period (>=1)
//   CS_HIGH_CYCLES : minimum ncs-high time between transactions (>=1)
// Build option EPCS_FLASH_BURST_EN: after a read ncs stays low in ST_HOLD; a
// read of the next word then clocks out only 32 data bits. Anything else
// raises ncs for CS_HIGH_CYCLES before being handled from idle.
// ---------------------------------------------------------------------------
module epcs_flash_reader
    import epcs_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    epcs_flash_reader_if.slave     bus,
    output logic                   dclk,
    output logic                   ncs,
    output logic                   asdo,
    input  logic                   data0,
    output epcs_state_t            state_dbg
);

    localparam logic [15:0] SETUP_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] HIGH_LAST  = 16'(CS_HIGH_CYCLES - 1);

    epcs_state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        ncs_q, ncs_n;
    logic [23:0] addr_q, addr_n;
    logic [31:0] rdata_q, rdata_n;

    logic                 go;
    logic [BIT_CNT_W-1:0] frame_len;
    logic [31:0]          tx_word;
    logic                 sh_done;
    logic [31:0]          rx_word;

    logic        req_rd;
    logic        req_wr;
    logic [23:0] word_addr;

    assign req_wr    = bus.sel && (bus.mem_wstrb != 4'd0);
    assign req_rd    = bus.sel && (bus.mem_wstrb == 4'd0);
    assign word_addr = bus.mem_addr & 24'hFF_FFFC;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ncs_q   <= 1'b1;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ncs_q   <= ncs_n;
            addr_q  <= addr_n;
            rdata_q <= rdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ncs_n     = ncs_q;
        addr_n    = addr_q;
        rdata_n   = rdata_q;
        go        = 1'b0;
        frame_len = FRAME_FULL;
        tx_word   = {READ_OPCODE, addr_q};

        case (state)
            ST_IDLE: begin
                if (req_wr) begin
                    rdata_n = '0;
                    state_n = ST_DONE;
                end else if (req_rd) begin
                    addr_n  = word_addr;
                    ncs_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_CS_SETUP;
                end
            end

            ST_CS_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    go      = 1'b1;
                    state_n = ST_SHIFT;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            ST_SHIFT: begin
                if (sh_done) begin
                    rdata_n = byte_reorder(rx_word);
`ifndef EPCS_FLASH_BURST_EN
                    ncs_n   = 1'b1;
`endif
                    state_n = ST_DONE;
                end
            end

            ST_DONE: begin
                cnt_n = '0;
`ifdef EPCS_FLASH_BURST_EN
                // ncs still low means a read just finished: keep the flash
                // streaming in case the next word is requested.
                state_n = ncs_q ? ST_CS_HIGH : ST_HOLD;
`else
                state_n = ST_CS_HIGH;
`endif
            end

            ST_CS_HIGH: begin
                if (cnt == HIGH_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

`ifdef EPCS_FLASH_BURST_EN
            ST_HOLD: begin
                if (req_rd && (word_addr == addr_q + 24'd4)) begin
                    addr_n    = word_addr;
                    go        = 1'b1;
                    frame_len = FRAME_DATA;
                    tx_word   = '0;
                    state_n   = ST_SHIFT;
                end else if (bus.sel) begin
                    // Not a continuation: close the frame. The initiator still
                    // holds the request, so idle picks it up afterwards.
                    ncs_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_CS_HIGH;
                end
            end
`endif

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    epcs_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .go        (go),
        .frame_len (frame_len),
        .tx_word   (tx_word),
        .data0     (data0),
        .dclk      (dclk),
        .asdo      (asdo),
        .done      (sh_done),
        .rx_word   (rx_word)
    );

    assign bus.mem_ready = (state == ST_DONE);
    assign bus.mem_rdata = rdata_q;
    assign ncs           = ncs_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_epcs_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_epcs_flash_reader
// Bench for epcs_flash_reader (CLK_DIV=2, CS_HIGH_CYCLES=8) with a serial
// flash model whose byte at address a reads back as a[7:0].
// Honours EPCS_FLASH_BURST_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_epcs_flash_reader;
    import epcs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    epcs_flash_reader_if bus();
    logic        dclk;
    logic        ncs;
    logic        asdo;
    logic        data0_r = 1'b0;
    epcs_state_t state_dbg;

    epcs_flash_reader #(
        .CLK_DIV        (2),
        .CS_HIGH_CYCLES (8)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .bus       (bus),
        .dclk      (dclk),
        .ncs       (ncs),
        .asdo      (asdo),
        .data0     (data0_r),
        .state_dbg (state_dbg)
    );

    // ---------------- flash model ----------------
    int          frames = 0;
    int          seen_frames = 0;
    int          fl_cnt = 0;
    int          fl_ones = 0;
    logic [31:0] fl_cmd = '0;
    int          dclk_edges = 0;
    int          ncs_edges = 0;

    always @(negedge ncs) frames++;
    always @(ncs) ncs_edges++;
    always @(dclk) dclk_edges++;

    always @(posedge dclk) begin
        if (ncs === 1'b0) begin
            if (frames != seen_frames) begin
                seen_frames = frames;
                fl_cnt  = 0;
                fl_cmd  = '0;
                fl_ones = 0;
            end
            if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], asdo};
            else if (asdo) fl_ones++;
            fl_cnt++;
        end
    end

    always @(negedge dclk) begin : flash_out
        int          idx;
        logic [23:0] ba;
        logic [7:0]  bv;
        if (ncs === 1'b0 && fl_cnt >= 32) begin
            idx = fl_cnt - 32;
            ba  = fl_cmd[23:0] + 24'(idx / 8);
            bv  = ba[7:0];
            data0_r = bv[3'(7 - (idx % 8))];
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic [23:0] addr, input logic [3:0] wstrb, input string tag,
                          output int lat, output logic [31:0] rdata, output logic ncs_rdy);
        logic got;
        @(negedge clk_sys);
        bus.sel       = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 2000) begin
            @(posedge clk_sys);
            #1;
            lat++;
            if (bus.mem_ready) got = 1'b1;
        end
        rdata   = bus.mem_rdata;
        ncs_rdy = ncs;
        check({tag, " ready seen"}, 32'(got), 32'd1);
        @(negedge clk_sys);
        bus.sel       = 1'b0;
        bus.mem_wstrb = 4'd0;
        @(posedge clk_sys);
        #1;
        check({tag, " ready one cycle"}, 32'(bus.mem_ready), 32'd0);
    endtask

`ifdef EPCS_FLASH_BURST_EN
    task automatic pulse_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask
`endif

    typedef struct {
        logic [23:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_cmd;
    } vec_t;

    vec_t tbl[7];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat;
        logic [31:0] rdata;
        logic        ncs_rdy;
        int          e_dclk, e_ncs, f0;
        logic        exp_ncs;
        int          cyc, nready, consec, ncs_hi;
        logic        prev_ready;
        int          rc[2];
        logic [31:0] rd[2];

        tbl[0] = '{24'h000100, 4'h0, 32'h0302_0100, 259, 32'h0300_0100};
        tbl[1] = '{24'h000102, 4'h0, 32'h0302_0100, 259, 32'h0300_0100};
        tbl[2] = '{24'h000010, 4'hF, 32'h0000_0000, 1,   32'h0};
        tbl[3] = '{24'h000FFC, 4'h0, 32'hFFFE_FDFC, 259, 32'h0300_0FFC};
        tbl[4] = '{24'hABCDE8, 4'h0, 32'hEBEA_E9E8, 259, 32'h03AB_CDE8};
        tbl[5] = '{24'h000020, 4'h1, 32'h0000_0000, 1,   32'h0};
        tbl[6] = '{24'hFFFFFF, 4'h0, 32'hFFFE_FDFC, 259, 32'h03FF_FFFC};

        bus.sel       = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wstrb = '0;

        // ---- reset values ----
        repeat (3) @(negedge clk_sys);
        check("reset mem_ready", 32'(bus.mem_ready), 32'd0);
        check("reset mem_rdata", bus.mem_rdata, 32'd0);
        check("reset dclk", 32'(dclk), 32'd0);
        check("reset ncs", 32'(ncs), 32'd1);
        check("reset asdo", 32'(asdo), 32'd0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 7; i++) begin
`ifdef EPCS_FLASH_BURST_EN
            pulse_reset();
            exp_ncs = (tbl[i].wstrb != 4'd0);
`else
            exp_ncs = 1'b1;
`endif
            e_dclk = dclk_edges;
            e_ncs  = ncs_edges;
            f0     = frames;
            exp_q.push_back(tbl[i].exp_rdata);
            do_req(tbl[i].addr, tbl[i].wstrb, $sformatf("vec%0d", i), lat, rdata, ncs_rdy);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d rdata", i), rdata, exp_q.pop_front());
            check($sformatf("vec%0d ncs at ready", i), 32'(ncs_rdy), 32'(exp_ncs));
            if (tbl[i].wstrb != 4'd0) begin
                check($sformatf("vec%0d write dclk quiet", i), 32'(dclk_edges - e_dclk), 32'd0);
                check($sformatf("vec%0d write ncs quiet", i), 32'(ncs_edges - e_ncs), 32'd0);
            end else begin
                check($sformatf("vec%0d command", i), fl_cmd, tbl[i].exp_cmd);
                check($sformatf("vec%0d asdo zero in data", i), 32'(fl_ones), 32'd0);
                check($sformatf("vec%0d one frame", i), 32'(frames - f0), 32'd1);
            end
            repeat (12) @(negedge clk_sys);
        end

        // ---- back-to-back reads, sel held through the ready cycle ----
`ifdef EPCS_FLASH_BURST_EN
        pulse_reset();
`endif
        exp_q.push_back(32'h0302_0100);
        exp_q.push_back(32'h0302_0100);
        @(negedge clk_sys);
        bus.sel       = 1'b1;
        bus.mem_addr  = 24'h000100;
        bus.mem_wstrb = 4'd0;
        cyc = 0; nready = 0; consec = 0; ncs_hi = 0; prev_ready = 1'b0;
        rc[0] = 0; rc[1] = 0; rd[0] = '0; rd[1] = '0;
        while (nready < 2 && cyc < 1200) begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (bus.mem_ready) begin
                if (prev_ready) consec++;
                rc[nready] = cyc;
                rd[nready] = bus.mem_rdata;
                nready++;
            end
            prev_ready = bus.mem_ready;
            if (nready == 1 && ncs) ncs_hi++;
        end
        @(negedge clk_sys);
        bus.sel = 1'b0;
        check("b2b ready count", 32'(nready), 32'd2);
        check("b2b no double pulse", 32'(consec), 32'd0);
        check("b2b acceptance spacing", 32'((rc[1] - rc[0]) >= 268), 32'd1);
        check("b2b ncs high gap", 32'(ncs_hi >= 8), 32'd1);
        check("b2b rdata 0", rd[0], exp_q.pop_front());
        check("b2b rdata 1", rd[1], exp_q.pop_front());
        repeat (12) @(negedge clk_sys);

        // ---- reset in the middle of a read ----
`ifdef EPCS_FLASH_BURST_EN
        pulse_reset();
`endif
        @(negedge clk_sys);
        bus.sel       = 1'b1;
        bus.mem_addr  = 24'h000100;
        bus.mem_wstrb = 4'd0;
        @(posedge clk_sys);
        repeat (99) @(posedge clk_sys);
        #2;
        check("midreset ncs active before", 32'(ncs), 32'd0);
        bus.sel = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midreset ncs", 32'(ncs), 32'd1);
        check("midreset dclk", 32'(dclk), 32'd0);
        check("midreset mem_ready", 32'(bus.mem_ready), 32'd0);
        check("midreset asdo", 32'(asdo), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        exp_q.push_back(32'h0706_0504);
        do_req(24'h000204, 4'h0, "after reset", lat, rdata, ncs_rdy);
        check("after reset latency", 32'(lat), 32'd259);
        check("after reset rdata", rdata, exp_q.pop_front());
        check("after reset command", fl_cmd, 32'h0300_0204);
        repeat (12) @(negedge clk_sys);

`ifdef EPCS_FLASH_BURST_EN
        // ---- burst continuation ----
        pulse_reset();
        exp_q.push_back(32'h0302_0100);
        do_req(24'h000200, 4'h0, "burst first", lat, rdata, ncs_rdy);
        check("burst first latency", 32'(lat), 32'd259);
        check("burst first rdata", rdata, exp_q.pop_front());
        e_ncs = ncs_edges;
        f0    = frames;
        exp_q.push_back(32'h0706_0504);
        do_req(24'h000204, 4'h0, "burst next", lat, rdata, ncs_rdy);
        check("burst next latency", 32'(lat), 32'd129);
        check("burst next rdata", rdata, exp_q.pop_front());
        check("burst next no new frame", 32'(frames - f0), 32'd0);
        check("burst next ncs held", 32'(ncs_edges - e_ncs), 32'd0);
        exp_q.push_back(32'h0302_0100);
        do_req(24'h000000, 4'h0, "burst break", lat, rdata, ncs_rdy);
        check("burst break latency", 32'(lat), 32'd268);
        check("burst break rdata", rdata, exp_q.pop_front());
        check("burst break command", fl_cmd, 32'h0300_0000);
        repeat (12) @(negedge clk_sys);
`endif

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
